// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: runs one instruction at a time through register-file read,
// ALU operand/result handshakes and an optional single-cycle write-back.
module reg_access_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [ADDR_W-1:0] src1_idx_i,
  input  logic [ADDR_W-1:0] src2_idx_i,
  input  logic [ADDR_W-1:0] dst_idx_i,
  input  logic              wb_en_i,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [ADDR_W-1:0] addr2_o,
  output logic              rd_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              wr_o,
  output logic [DATA_W-1:0] data_in_o,
  input  logic [DATA_W-1:0] data_out1_i,
  input  logic [DATA_W-1:0] data_out2_i,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_data_i,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT_RES, WRITE} state_e;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d, dst_q, dst_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, data_in_q, data_in_d;
  logic [7:0] cnt_q, cnt_d;
  logic wb_q, wb_d, rd_q, rd_d, wr_q, wr_d, op_valid_q, op_valid_d;
  logic done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic accept, res_hit, expire;
  assign accept  = state_q == IDLE && instr_valid_i;
  assign res_hit = state_q == WAIT_RES && res_valid_i;
  // a result arriving on the final count takes priority over the abort
  assign expire  = state_q == WAIT_RES && !res_valid_i && cnt_q == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = instr_valid_i ? READ : IDLE;
      READ:     state_d = ISSUE;
      ISSUE:    state_d = op_ready_i ? WAIT_RES : ISSUE;
      WAIT_RES: state_d = res_hit ? (wb_q ? WRITE : IDLE) : (expire ? IDLE : WAIT_RES);
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    addr1_d    = accept ? src1_idx_i : addr1_q;
    addr2_d    = accept ? src2_idx_i : addr2_q;
    dst_d      = accept ? dst_idx_i : dst_q;
    wb_d       = accept ? wb_en_i : wb_q;
    op_a_d     = state_q == READ ? data_out1_i : op_a_q;
    op_b_d     = state_q == READ ? data_out2_i : op_b_q;
    cnt_d      = state_q == WAIT_RES ? cnt_q + 8'd1 : 8'd0;
    wr_addr_d  = res_hit && wb_q ? dst_q : wr_addr_q;
    data_in_d  = res_hit && wb_q ? res_data_i : data_in_q;
    rd_d       = state_d == READ;
    op_valid_d = state_d == ISSUE;
    wr_d       = state_d == WRITE;
    ready_d    = state_d == IDLE;
    done_d     = state_q == WRITE || (res_hit && !wb_q);
    err_d      = expire;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr1_q    <= '0;
      addr2_q    <= '0;
      dst_q      <= '0;
      wb_q       <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      data_in_q  <= '0;
      rd_q       <= 1'b0;
      op_valid_q <= 1'b0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      dst_q      <= dst_d;
      wb_q       <= wb_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      data_in_q  <= data_in_d;
      rd_q       <= rd_d;
      op_valid_q <= op_valid_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  assign instr_ready_o = ready_q;
  assign addr1_o       = addr1_q;
  assign addr2_o       = addr2_q;
  assign rd_o          = rd_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_o          = wr_q;
  assign data_in_o     = data_in_q;
  assign op_valid_o    = op_valid_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: drives reg_access_ctrl with a register file and ALU environment
// and checks every instruction against an architectural register/timeout model.
module tb_reg_access_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic instr_valid = 1'b0, instr_ready;
  logic [2:0] src1 = '0, src2 = '0, dst = '0;
  logic wb_en = 1'b0;
  logic [2:0] addr1, addr2, wr_addr;
  logic rd, wr, op_valid, op_ready = 1'b0, res_valid = 1'b0, done, err;
  logic [7:0] data_in, data_out1, data_out2, op_a, op_b, res_data = '0;
  logic [7:0] rf [8] = '{8'd1, 8'd3, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
  logic [7:0] mrf [8];
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int s1, s2, d, wb, rdly, resd, add;
    logic [7:0] k;
    int exp_wr, exp_err;
  } vec_t;

  reg_access_ctrl #(.DATA_W(8), .ADDR_W(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .src1_idx_i(src1), .src2_idx_i(src2), .dst_idx_i(dst), .wb_en_i(wb_en),
    .addr1_o(addr1), .addr2_o(addr2), .rd_o(rd),
    .wr_addr_o(wr_addr), .wr_o(wr), .data_in_o(data_in),
    .data_out1_i(data_out1), .data_out2_i(data_out2),
    .op_valid_o(op_valid), .op_ready_i(op_ready), .op_a_o(op_a), .op_b_o(op_b),
    .res_valid_i(res_valid), .res_data_i(res_data),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  assign data_out1 = rf[addr1];
  assign data_out2 = rf[addr2];
  always @(posedge clk) if (wr) rf[wr_addr] <= data_in;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_ctl"}, {rd, wr, op_valid, done, err}, 0);
    chk({tag, "_addr"}, {addr1, addr2, wr_addr}, 0);
    chk({tag, "_data"}, {data_in, op_a, op_b}, 0);
  endtask

  task automatic run(input vec_t v);
    int rd_n = 0, ov_n = 0, wr_n = 0, done_n = 0, err_n = 0, both = 0, unstable = 0;
    int rd_c = -1, ov_c = -1, wr_c = -1, end_c = -1, wcyc = -1, n = 0;
    logic [2:0] a1 = '0, a2 = '0, wa = '0;
    logic [7:0] oa = '0, ob = '0, di = '0, ea, eb, er;
    logic acc = 1'b0;
    ea = mrf[v.s1];
    eb = mrf[v.s2];
    er = v.add != 0 ? ea + eb : v.k;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before", instr_ready, 1);
    src1 = 3'(v.s1); src2 = 3'(v.s2); dst = 3'(v.d); wb_en = v.wb != 0;
    instr_valid = 1'b1;
    for (int c = 1; c <= 80 && (end_c < 0 || c <= end_c + 2); c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (rd) begin
        rd_n++;
        if (rd_c < 0) begin rd_c = c; a1 = addr1; a2 = addr2; end
      end
      if (rd && wr) both++;
      if (acc) wcyc++;
      if (op_valid) begin
        ov_n++;
        if (ov_c < 0) begin ov_c = c; oa = op_a; ob = op_b; end
        else if (op_a !== oa || op_b !== ob) unstable++;
      end
      op_ready = op_valid && ov_n > v.rdly;
      if (op_ready) acc = 1'b1;
      res_valid = wcyc == v.resd;
      res_data = v.add != 0 ? op_a + op_b : v.k;
      if (wr) begin wr_n++; wr_c = c; wa = wr_addr; di = data_in; end
      if (done) begin done_n++; if (end_c < 0) end_c = c; end
      if (err) begin err_n++; if (end_c < 0) end_c = c; end
    end
    op_ready = 1'b0;
    res_valid = 1'b0;
    chk("finished", end_c >= 0, 1);
    chk("rd_count", rd_n, 1);
    chk("rd_cycle", rd_c, 1);
    chk("addr1", a1, v.s1);
    chk("addr2", a2, v.s2);
    chk("opv_cycle", ov_c, 2);
    chk("opv_count", ov_n, v.rdly + 1);
    chk("op_a", oa, ea);
    chk("op_b", ob, eb);
    chk("op_stable", unstable, 0);
    chk("rd_wr_overlap", both, 0);
    chk("wr_count", wr_n, v.exp_wr);
    if (v.exp_wr != 0) begin
      chk("wr_addr", wa, v.d);
      chk("data_in", di, er);
      chk("wr_cycle", wr_c, 4 + v.rdly + v.resd);
    end
    chk("done_count", done_n, v.exp_err == 0);
    chk("err_count", err_n, v.exp_err);
    chk("end_cycle", end_c, v.exp_err != 0 ? 3 + v.rdly + TO :
                            (v.exp_wr != 0 ? 5 : 4) + v.rdly + v.resd);
    chk("ready_after", instr_ready, 1);
    if (v.exp_wr != 0) mrf[v.d] = er;
  endtask

  initial begin
    vec_t tbl [7];
    vec_t rv;
    int quiet;
    for (int i = 0; i < 8; i++) mrf[i] = rf[i];
    tbl = '{
      '{0, 1, 2, 1, 0, 0, 1, 8'h04, 1, 0},
      '{2, 2, 3, 1, 0, 0, 1, 8'h00, 1, 0},
      '{3, 0, 4, 1, 5, 2, 1, 8'h00, 1, 0},
      '{1, 2, 5, 0, 0, 1, 0, 8'h55, 0, 0},
      '{4, 1, 6, 1, 0, 16, 0, 8'hAA, 0, 1},
      '{4, 1, 6, 1, 1, 15, 0, 8'hA5, 1, 0},
      '{6, 6, 6, 1, 0, 0, 1, 8'h00, 1, 0}
    };
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    chk("reset_ready", instr_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run(tbl[i]);
    // reset asserted while operands wait in ISSUE
    @(negedge clk);
    src1 = 3'd0; src2 = 3'd1; dst = 3'd7; wb_en = 1'b1; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_opvalid", op_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr || done || err || rd || op_valid) quiet++;
    end
    chk("post_reset_quiet", quiet, 0);
    run('{0, 1, 7, 1, 0, 0, 1, 8'h00, 1, 0});
    for (int i = 0; i < 25; i++) begin
      rv.s1 = int'($urandom_range(0, 7));
      rv.s2 = int'($urandom_range(0, 7));
      rv.d = int'($urandom_range(0, 7));
      rv.wb = int'($urandom_range(0, 1));
      rv.rdly = int'($urandom_range(0, 3));
      rv.resd = $urandom_range(0, 5) == 0 ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 4));
      rv.add = int'($urandom_range(0, 1));
      rv.k = 8'($urandom);
      rv.exp_err = rv.resd >= TO;
      rv.exp_wr = rv.wb != 0 && rv.exp_err == 0;
      run(rv);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("regfile_r%0d", i), rf[i], mrf[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
Initiator side of the 8-entry register file interface. Accepts decoded instructions (two source indices, one destination index, writeback flag) from the decoder. It sequences the register-file read strobe, captures both operands and hands them to the ALU over a valid/ready handshake. It then waits for the result and issues a single-cycle write strobe back to the register file. One instruction is in flight at a time; it sits between the decoder, the register file and the ALU.

Parameters:
DATA_W, 8, operand/result width (matches register file data width)
ADDR_W, 3, register index width (8 registers)
TIMEOUT, 16, max cycles to wait for the ALU result before aborting; range 1..255

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  decoder presents an instruction
instr_ready  output  1  controller can accept an instruction (high only in IDLE)
src1_idx  input  ADDR_W  first source register index
src2_idx  input  ADDR_W  second source register index
dst_idx  input  ADDR_W  destination register index
wb_en  input  1  1 = result is written back to dst_idx
addr1  output  ADDR_W  register file read address 1
addr2  output  ADDR_W  register file read address 2
rd  output  1  register file read strobe
wr_addr  output  ADDR_W  register file write address
wr  output  1  register file write strobe
data_in  output  DATA_W  register file write data
data_out1  input  DATA_W  register file read data 1 (combinational from addr1)
data_out2  input  DATA_W  register file read data 2 (combinational from addr2)
op_valid  output  1  operands valid to ALU
op_ready  input  1  ALU accepts operands
op_a  output  DATA_W  operand A (from src1)
op_b  output  DATA_W  operand B (from src2)
res_valid  input  1  ALU result valid
res_data  input  DATA_W  ALU result
done  output  1  one-cycle pulse: instruction retired
err  output  1  one-cycle pulse: result timeout, instruction aborted

Behaviour:
- Reset (async, rst_n=0): state=IDLE. rd, wr, op_valid, done and err are 0. addr1, addr2, wr_addr, data_in, op_a and op_b are 0. The timeout counter is 0. Outputs go to these values immediately, not at the next edge.
- All outputs are registered (driven from flops); rd and wr are never high in the same cycle.
- FSM states: IDLE, READ, ISSUE, WAIT_RES, WRITE.
- IDLE: instr_ready=1. On instr_valid, latch src1_idx, src2_idx, dst_idx and wb_en; addr1/addr2 <= src indices; rd <= 1; go to READ.
- READ (exactly 1 cycle): rd=1. At the end of the cycle, op_a <= data_out1, op_b <= data_out2, rd <= 0, op_valid <= 1; go to ISSUE.
- ISSUE: hold op_valid, op_a and op_b stable until op_ready=1. On the accepting edge: op_valid <= 0, timeout counter <= 0; go to WAIT_RES.
- WAIT_RES:
  - Counter increments each cycle.
  - On res_valid=1: latch res_data. If the latched wb_en=1, data_in <= res_data, wr_addr <= dst, wr <= 1, and go to WRITE. If wb_en=0, done <= 1 and go to IDLE.
  - If the counter reaches TIMEOUT-1 without res_valid: err <= 1; go to IDLE with no write.
  - res_valid in the same cycle as the last count wins over the timeout.
- WRITE (exactly 1 cycle): wr=1; at the end, wr <= 0, done <= 1; go to IDLE.
- Ignored inputs: res_valid outside WAIT_RES; instr_valid outside IDLE (decoder must hold it).
- Latency with op_ready=1 and res_valid on the first WAIT_RES cycle: accept -> rd at +1, op_valid at +2, wr at +4, done at +5. Next instr_ready follows done.
- Hazards: a write completes before IDLE, so a following instruction reading dst sees the new value with no forwarding. src1=src2 is legal (both operands equal). dst equal to a source is legal.
- Reset mid-operation: the instruction is dropped, no write is issued, and there is no done/err pulse.

Test Plan:
- Reset values: r0=1, r1=3; instr src1=0, src2=1, dst=2, wb_en=1; ALU returns 4 one cycle after accept -> rd one cycle with addr1=0/addr2=1; op_a=1, op_b=3; wr one cycle with wr_addr=2, data_in=4; done pulse; then reading r2 returns 4.
- Backpressure: op_ready held low 5 cycles -> op_valid, op_a and op_b stay stable for all 5 cycles; no wr until the result arrives.
- wb_en=0, result 0x55 -> wr never asserts; done pulses; register file unchanged.
- TIMEOUT=16, res_valid never asserted -> err pulses exactly once after 16 WAIT_RES cycles; no wr; instr_ready returns high.
- Back-to-back dependent pair: (r0+r1 -> r2) then (r2,r2 -> r3) with ALU adding -> second instruction reads r2=4; writes r3=8.
- rst_n pulsed low during ISSUE -> all outputs 0 asynchronously; no wr, done or err; the next instruction executes normally.
